// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

  // Owner of a read that is in flight through the memory latency.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  // Direction encoding used across the processor/memory interface.
  localparam logic rd_wr_read  = 1'b1;
  localparam logic rd_wr_write = 1'b0;

  // Access sizes.
  localparam logic [1:0] sz_byte = 2'd0;
  localparam logic [1:0] sz_half = 2'd1;
  localparam logic [1:0] sz_word = 2'd2;

endpackage

// File: rtl/mem_arbiter_tag_pipe.sv
// Owner-tag delay line matching the memory read latency, so returning data
// can be steered to the requester that issued the read.
module arb_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  arb_owner_t tag_in,
  output arb_owner_t tag_out
);

  arb_owner_t tag_p [RD_LAT];

  // Shift tags one stage per cycle; reset discards every in-flight read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < RD_LAT; k++) tag_p[k] <= OWN_NONE;
    end else begin
      tag_p[0] <= tag_in;
      for (int k = 1; k < RD_LAT; k++) tag_p[k] <= tag_p[k-1];
    end
  end

  assign tag_out = tag_p[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory between the instruction-fetch and data ports.
// Data has fixed priority; a saturating starvation counter forces a fetch
// grant after STARVE_MAX consecutive denials.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_rd_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_access_size,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // memory side
  output logic        m_enable,
  output logic [31:0] m_addr,
  output logic        m_rd_wr,
  output logic [1:0]  m_access_size,
  output logic [31:0] m_data_in,
  input  logic [31:0] m_data_out
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       i_win;
  logic       d_win;
  arb_owner_t tag_in;
  arb_owner_t tag_out;

  // Pick this cycle's winner; nothing is granted while reset is asserted.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (reset) begin
      if (i_req && (!d_req || starve_cnt >= STARVE_LIM)) i_win = 1'b1;
      else if (d_req)                                    d_win = 1'b1;
    end
  end

  assign i_gnt = i_win;
  assign d_gnt = d_win;

  // Count consecutive cycles fetch is requesting but losing; saturates.
  always_ff @(posedge clk) begin
    if (!reset)                   starve_cnt <= 4'd0;
    else if (!i_req || i_win)     starve_cnt <= 4'd0;
    else if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
  end

  // Drive the winner's fields onto the memory and tag the read owner.
  always_comb begin
    m_enable      = 1'b0;
    m_addr        = 32'd0;
    m_rd_wr       = rd_wr_read;
    m_access_size = sz_word;
    m_data_in     = 32'd0;
    tag_in        = OWN_NONE;
    if (i_win) begin
      m_enable      = 1'b1;
      m_addr        = i_addr;
      tag_in        = OWN_I;
    end else if (d_win) begin
      m_enable      = 1'b1;
      m_addr        = d_addr;
      m_rd_wr       = d_rd_wr;
      m_access_size = d_access_size;
      if (d_rd_wr == rd_wr_read) tag_in    = OWN_D;
      else                       m_data_in = d_wdata;
    end
  end

  arb_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Memory data is shared; the owner tag decides which port sees it valid.
  assign i_rvalid = (tag_out == OWN_I);
  assign d_rvalid = (tag_out == OWN_D);
  assign i_rdata  = m_data_out;
  assign d_rdata  = m_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances with RD_LAT=1 (a) and
// RD_LAT=3 (b) share the same request stimulus, each backed by a memory
// model of matching latency.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_rd_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_access_size;

  logic        i_gnt_a, i_rvalid_a, d_gnt_a, d_rvalid_a, m_enable_a, m_rd_wr_a;
  logic [31:0] i_rdata_a, d_rdata_a, m_addr_a, m_data_in_a, m_data_out_a;
  logic [1:0]  m_access_size_a;
  logic        i_gnt_b, i_rvalid_b, d_gnt_b, d_rvalid_b, m_enable_b, m_rd_wr_b;
  logic [31:0] i_rdata_b, d_rdata_b, m_addr_b, m_data_in_b, m_data_out_b;
  logic [1:0]  m_access_size_b;

  logic [31:0] mem [0:255];
  logic [31:0] rp1, rp2;
  logic        pend_i, pend_d;
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_a), .i_rvalid(i_rvalid_a), .i_rdata(i_rdata_a),
    .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_access_size(d_access_size), .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
    .m_enable(m_enable_a), .m_addr(m_addr_a), .m_rd_wr(m_rd_wr_a),
    .m_access_size(m_access_size_a), .m_data_in(m_data_in_a), .m_data_out(m_data_out_a)
  );

  mem_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_b), .i_rvalid(i_rvalid_b), .i_rdata(i_rdata_b),
    .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_access_size(d_access_size), .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
    .m_enable(m_enable_b), .m_addr(m_addr_b), .m_rd_wr(m_rd_wr_b),
    .m_access_size(m_access_size_b), .m_data_in(m_data_in_b), .m_data_out(m_data_out_b)
  );

  // Memory model: word k initialises to 0xA000_0000+k; writes come from
  // instance a (both instances see identical grants). Read data for a
  // arrives one cycle after the grant, for b three cycles after.
  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'hA000_0000 + 32'(k);
    end else if (m_enable_a && m_rd_wr_a == rd_wr_write) begin
      mem[m_addr_a[9:2]] <= m_data_in_a;
    end
    m_data_out_a <= mem[m_addr_a[9:2]];
    rp1          <= mem[m_addr_b[9:2]];
    rp2          <= rp1;
    m_data_out_b <= rp2;
  end

  // Remember requests left waiting so the bench can flag a dropped request.
  always @(posedge clk) begin
    pend_i <= reset && i_req && !i_gnt_a;
    pend_d <= reset && d_req && !d_gnt_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs after the falling edge, then settle.
  task automatic drv(input logic rst, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic drw, input logic [31:0] da,
                     input logic [31:0] dw, input logic [1:0] dsz);
    @(negedge clk);
    reset = rst; i_req = ir; i_addr = ia;
    d_req = dr; d_rd_wr = drw; d_addr = da; d_wdata = dw; d_access_size = dsz;
    #1;
    if (pend_i) chk("proto_i_hold", {31'd0, i_req}, 32'd1);
    if (pend_d) chk("proto_d_hold", {31'd0, d_req}, 32'd1);
  endtask

  task automatic idle();
    drv(1'b1, 1'b0, 32'd0, 1'b0, rd_wr_read, 32'd0, 32'd0, sz_word);
  endtask

  initial begin
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_rd_wr = rd_wr_read;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_access_size = sz_word;
    pend_i = 1'b0; pend_d = 1'b0;

    // Reset with both ports requesting: nothing granted, memory idle.
    drv(1'b0, 1'b1, 32'h8002_0000, 1'b1, rd_wr_read, 32'h8002_0004, 32'd0, sz_word);
    drv(1'b0, 1'b1, 32'h8002_0000, 1'b1, rd_wr_read, 32'h8002_0004, 32'd0, sz_word);
    chk("rst_i_gnt",    {31'd0, i_gnt_a},    32'd0);
    chk("rst_d_gnt",    {31'd0, d_gnt_a},    32'd0);
    chk("rst_m_enable", {31'd0, m_enable_a}, 32'd0);
    chk("rst_m_rd_wr",  {31'd0, m_rd_wr_a},  32'd1);
    chk("rst_m_addr",   m_addr_a,            32'd0);
    chk("rst_i_rvalid", {31'd0, i_rvalid_a}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid_b}, 32'd0);
    chk("rst_starve",   {28'd0, dut_a.starve_cnt}, 32'd0);

    // Fetch only: three consecutive words.
    drv(1'b1, 1'b1, 32'h8002_0000, 1'b0, rd_wr_read, 32'd0, 32'd0, sz_word);
    chk("f0_i_gnt",   {31'd0, i_gnt_a},    32'd1);
    chk("f0_m_addr",  m_addr_a,            32'h8002_0000);
    chk("f0_m_size",  {30'd0, m_access_size_a}, {30'd0, sz_word});
    chk("f0_m_rdwr",  {31'd0, m_rd_wr_a},  32'd1);
    drv(1'b1, 1'b1, 32'h8002_0004, 1'b0, rd_wr_read, 32'd0, 32'd0, sz_word);
    chk("f1_i_gnt",   {31'd0, i_gnt_a},    32'd1);
    chk("f1_i_rvalid", {31'd0, i_rvalid_a}, 32'd1);
    chk("f1_i_rdata", i_rdata_a,           32'hA000_0000);
    drv(1'b1, 1'b1, 32'h8002_0008, 1'b0, rd_wr_read, 32'd0, 32'd0, sz_word);
    chk("f2_i_gnt",   {31'd0, i_gnt_a},    32'd1);
    chk("f2_i_rdata", i_rdata_a,           32'hA000_0001);
    chk("f2_b_rvalid", {31'd0, i_rvalid_b}, 32'd0);
    idle();
    chk("f3_i_rvalid", {31'd0, i_rvalid_a}, 32'd1);
    chk("f3_i_rdata", i_rdata_a,           32'hA000_0002);
    chk("f3_d_rvalid", {31'd0, d_rvalid_a}, 32'd0);
    chk("f3_m_enable", {31'd0, m_enable_a}, 32'd0);
    chk("f3_b_rvalid", {31'd0, i_rvalid_b}, 32'd1);
    chk("f3_b_rdata", i_rdata_b,           32'hA000_0000);
    idle();
    chk("f4_a_rvalid", {31'd0, i_rvalid_a}, 32'd0);
    chk("f4_b_rdata", i_rdata_b,           32'hA000_0001);
    idle();
    chk("f5_b_rvalid", {31'd0, i_rvalid_b}, 32'd1);
    chk("f5_b_rdata", i_rdata_b,           32'hA000_0002);
    chk("f5_b_d_rvalid", {31'd0, d_rvalid_b}, 32'd0);
    idle();

    // Data write then read of the same word.
    drv(1'b1, 1'b0, 32'd0, 1'b1, rd_wr_write, 32'h8002_0100, 32'hDEAD_BEEF, sz_word);
    chk("w_d_gnt",    {31'd0, d_gnt_a},    32'd1);
    chk("w_m_rdwr",   {31'd0, m_rd_wr_a},  32'd0);
    chk("w_m_data",   m_data_in_a,         32'hDEAD_BEEF);
    drv(1'b1, 1'b0, 32'd0, 1'b1, rd_wr_read, 32'h8002_0100, 32'd0, sz_word);
    chk("r_d_gnt",    {31'd0, d_gnt_a},    32'd1);
    chk("r_no_wr_rvalid", {31'd0, d_rvalid_a}, 32'd0);
    chk("r_m_rdwr",   {31'd0, m_rd_wr_a},  32'd1);
    idle();
    chk("r_d_rvalid", {31'd0, d_rvalid_a}, 32'd1);
    chk("r_d_rdata",  d_rdata_a,           32'hDEAD_BEEF);
    chk("r_idle_data_in", m_data_in_a,     32'd0);
    idle();
    chk("r_b_wr_none", {31'd0, d_rvalid_b}, 32'd0);
    idle();
    chk("r_b_d_rvalid", {31'd0, d_rvalid_b}, 32'd1);
    chk("r_b_d_rdata", d_rdata_b,          32'hDEAD_BEEF);

    // Contention: data wins four cycles, then fetch is forced through.
    for (int k = 0; k < 10; k++) begin
      drv(1'b1, 1'b1, 32'h8002_0000, 1'b1, rd_wr_read, 32'h8002_0004, 32'd0, sz_word);
      chk("cont_i_gnt",  {31'd0, i_gnt_a}, (k % 5 == 4) ? 32'd1 : 32'd0);
      chk("cont_d_gnt",  {31'd0, d_gnt_a}, (k % 5 == 4) ? 32'd0 : 32'd1);
      chk("cont_starve", {28'd0, dut_a.starve_cnt}, 32'(k % 5));
    end
    drv(1'b1, 1'b0, 32'd0, 1'b1, rd_wr_read, 32'h8002_0004, 32'd0, sz_word);
    chk("cont_d_last", {31'd0, d_gnt_a}, 32'd1);
    idle(); idle(); idle();

    // Alternating fetch/data reads, three-cycle latency instance.
    drv(1'b1, 1'b1, 32'h8002_0000, 1'b0, rd_wr_read, 32'd0, 32'd0, sz_word);
    drv(1'b1, 1'b0, 32'd0, 1'b1, rd_wr_read, 32'h8002_0008, 32'd0, sz_word);
    drv(1'b1, 1'b1, 32'h8002_0004, 1'b0, rd_wr_read, 32'd0, 32'd0, sz_word);
    chk("mx2_i_rvalid", {31'd0, i_rvalid_b}, 32'd0);
    chk("mx2_d_rvalid", {31'd0, d_rvalid_b}, 32'd0);
    drv(1'b1, 1'b0, 32'd0, 1'b1, rd_wr_read, 32'h8002_000C, 32'd0, sz_word);
    chk("mx3_i_rvalid", {31'd0, i_rvalid_b}, 32'd1);
    chk("mx3_d_rvalid", {31'd0, d_rvalid_b}, 32'd0);
    chk("mx3_i_rdata",  i_rdata_b,           32'hA000_0000);
    idle();
    chk("mx4_d_rvalid", {31'd0, d_rvalid_b}, 32'd1);
    chk("mx4_i_rvalid", {31'd0, i_rvalid_b}, 32'd0);
    chk("mx4_d_rdata",  d_rdata_b,           32'hA000_0002);
    idle();
    chk("mx5_i_rvalid", {31'd0, i_rvalid_b}, 32'd1);
    chk("mx5_i_rdata",  i_rdata_b,           32'hA000_0001);
    idle();
    chk("mx6_d_rvalid", {31'd0, d_rvalid_b}, 32'd1);
    chk("mx6_d_rdata",  d_rdata_b,           32'hA000_0003);
    idle();

    // Reset one cycle after a data read grant drops that read.
    drv(1'b1, 1'b0, 32'd0, 1'b1, rd_wr_read, 32'h8002_0008, 32'd0, sz_word);
    chk("x0_d_gnt",    {31'd0, d_gnt_b},    32'd1);
    drv(1'b0, 1'b1, 32'h8002_0004, 1'b1, rd_wr_read, 32'h8002_0000, 32'd0, sz_word);
    chk("x1_i_gnt",    {31'd0, i_gnt_b},    32'd0);
    chk("x1_d_gnt",    {31'd0, d_gnt_b},    32'd0);
    chk("x1_m_enable", {31'd0, m_enable_b}, 32'd0);
    drv(1'b1, 1'b0, 32'd0, 1'b1, rd_wr_read, 32'h8002_0000, 32'd0, sz_word);
    chk("x2_d_gnt",    {31'd0, d_gnt_b},    32'd1);
    chk("x2_starve",   {28'd0, dut_b.starve_cnt}, 32'd0);
    chk("x2_d_rvalid", {31'd0, d_rvalid_b}, 32'd0);
    idle();
    chk("x3_dropped",  {31'd0, d_rvalid_b}, 32'd0);
    chk("x3_a_rvalid", {31'd0, d_rvalid_a}, 32'd1);
    chk("x3_a_rdata",  d_rdata_a,           32'hA000_0000);
    idle();
    chk("x4_d_rvalid", {31'd0, d_rvalid_b}, 32'd0);
    idle();
    chk("x5_d_rvalid", {31'd0, d_rvalid_b}, 32'd1);
    chk("x5_d_rdata",  d_rdata_b,           32'hA000_0000);

    // Byte access passes size and unaligned address through.
    drv(1'b1, 1'b0, 32'd0, 1'b1, rd_wr_read, 32'h8002_0003, 32'd0, sz_byte);
    chk("b_d_gnt",  {31'd0, d_gnt_a},         32'd1);
    chk("b_m_size", {30'd0, m_access_size_a}, {30'd0, sz_byte});
    chk("b_m_addr", m_addr_a,                 32'h8002_0003);
    idle(); idle(); idle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
